single_mips_ins_mem_loader: RTL

SINGLE_MIPS_INS_MEM_LOADER -- requirements
Module: single_mips_ins_mem_loader

---
 rtl/single_mips_pkg.sv | 16 +
 rtl/loader_word_assembler.sv | 30 +++
 rtl/single_mips_ins_mem_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/single_mips_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states and boot-stream field sizes.
package single_mips_pkg;

  typedef enum logic [2:0] {
    HDR     = 3'd0,
    PAYLOAD = 3'd1,
    CSUM    = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int CSUM_BYTES = 1;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs MSB-first bytes into 32-bit words; word_valid is combinational in the cycle the last byte is enabled.
// No backpressure of its own: a byte is taken whenever byte_en is high, and state holds otherwise.
module loader_word_assembler
  import single_mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_en,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [23:0] shift;
  logic [1:0]  cnt;

  assign word_valid = byte_en && (cnt == 2'(WORD_BYTES - 1));
  assign word_data  = {shift, byte_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      cnt   <= '0;
    end else if (byte_en) begin
      shift <= {shift[15:0], byte_in};
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/single_mips_ins_mem_loader.sv
// Boot loader: parses count/words/checksum byte stream, writes instruction memory one cycle after each word's last byte.
// byte_ready is high in HDR/PAYLOAD/CSUM (no stall on writes) and low once the load is DONE or ERR.
module single_mips_ins_mem_loader
  import single_mips_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_DEPTH_WORDS = 256
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  ins_mem_WE,
  output logic [ADDR_WIDTH-1:0] ins_mem_WA,
  output logic [DATA_WIDTH-1:0] ins_mem_WD,
  output logic                  CPU_RST_N,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int IDX_W = $clog2(MEM_DEPTH_WORDS) + 1;

  state_t            state, state_nxt;
  logic              hdr_cnt;
  logic [7:0]        hdr_hi;
  logic [15:0]       hdr_n;
  logic [IDX_W-1:0]  n_words;
  logic [IDX_W-1:0]  word_index;
  logic [7:0]        csum;
  logic              accept;
  logic              word_valid;
  logic [31:0]       word_data;

  assign accept = byte_valid && byte_ready;
  assign hdr_n  = {hdr_hi, byte_in};

  loader_word_assembler u_asm (
    .clk        (CLK),
    .rst_n      (RST_N),
    .byte_in    (byte_in),
    .byte_en    (accept && (state == PAYLOAD)),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= HDR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR: begin
        if (accept && (hdr_cnt == 1'(HDR_BYTES - 1))) begin
          if (hdr_n == 16'd0)
            state_nxt = CSUM;
          else if ({16'd0, hdr_n} > 32'(MEM_DEPTH_WORDS))
            state_nxt = ERR;
          else
            state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // n_words >= 1 here, so the subtraction cannot underflow
        if (word_valid && (word_index == n_words - 1'b1))
          state_nxt = CSUM;
      end
      CSUM: begin
        if (accept)
          state_nxt = (byte_in == csum) ? DONE : ERR;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hdr_cnt    <= 1'b0;
      hdr_hi     <= '0;
      n_words    <= '0;
      word_index <= '0;
      csum       <= '0;
      byte_ready <= 1'b1;
      ins_mem_WE <= 1'b0;
      ins_mem_WA <= '0;
      ins_mem_WD <= '0;
      CPU_RST_N  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      ins_mem_WE <= 1'b0;
      byte_ready <= (state_nxt == HDR) || (state_nxt == PAYLOAD) || (state_nxt == CSUM);
      load_done  <= (state_nxt == DONE);
      load_err   <= (state_nxt == ERR);
      CPU_RST_N  <= (state_nxt == DONE);

      if (accept && ((state == HDR) || (state == PAYLOAD)))
        csum <= csum ^ byte_in;

      if (accept && (state == HDR)) begin
        hdr_cnt <= 1'b1;
        if (hdr_cnt == 1'b0) hdr_hi  <= byte_in;
        else                 n_words <= IDX_W'(hdr_n);
      end

      if (word_valid) begin
        ins_mem_WE <= 1'b1;
        ins_mem_WA <= ADDR_WIDTH'({word_index, 2'b00});
        ins_mem_WD <= DATA_WIDTH'(word_data);
        word_index <= word_index + 1'b1;
      end
    end
  end

endmodule
